alu_operand_loader: RTL and testbench
=====================================

Name: alu_operand_loader

Overview:
Input stage that sits directly upstream of the 4-bit ALU. It takes one shared 4-bit switch bank and a raw load push-button, and sequentially captures operand A, then operand B, then the opcode. After the opcode is captured it holds start high, so the ALU result and flags stay on the 7-segment displays and flag LEDs. The block handles button synchronisation, debouncing, edge detection and operand sequencing, and drives the ALU a/b/op/start inputs from registers.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronised samples needed to accept a button level change (10 ms at 50 MHz); the bench overrides this to 4.

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous active-high reset
sw  input  4  switch bank; its value is captured as A, B or op depending on state
btn_load  input  1  raw active-high load button, asynchronous to clk
btn_clear  input  1  raw active-high clear, asynchronous to clk; synchronised but not debounced
a  output  4  registered operand A to the ALU
b  output  4  registered operand B to the ALU
op  output  4  registered opcode to the ALU
start  output  1  registered; high only in S_RUN
state_led  output  4  one-hot state indicator: bit0 S_A, bit1 S_B, bit2 S_OP, bit3 S_RUN
op_valid  output  1  combinational, equals (op <= 4'd2); marks add/sub/mul

Behaviour:
- Reset, on the rst-high edge: a=b=op=0, start=0, state=S_A (state_led=4'b0001), synchroniser, debouncer counter and debounced level all cleared. Reset overrides every other input and can occur mid-sequence.
- Synchroniser: 2-flop chain on btn_load and on btn_clear.
- Debouncer:
  - The counter increments on each edge where synced != debounced level, and clears to 0 on each edge where they are equal.
  - When the counter is DEBOUNCE_CYCLES-1 and synced still differs, the debounced level toggles and the counter clears.
  - load_evt = debounced & ~debounced_d, a 1-cycle pulse.
- Latency: if btn_load is first sampled high at edge k and stays high, load_evt is high in the cycle after edge k+1+DEBOUNCE_CYCLES, and the capture happens at edge k+2+DEBOUNCE_CYCLES. A release is debounced the same way and produces no event.
- Glitches: a high pulse shorter than DEBOUNCE_CYCLES synced cycles produces no load_evt.
- FSM transitions on load_evt:
  - S_A -> S_B with a<=sw.
  - S_B -> S_OP with b<=sw.
  - S_OP -> S_RUN with op<=sw and start<=1.
  - S_RUN -> S_A with start<=0; a, b and op are retained and nothing is captured.
- Without load_evt, the state and registers hold.
- Clear: while synced btn_clear=1, state=S_A, a=b=op=0 and start=0 on every edge. Clear beats load_evt arriving on the same edge, and a load_evt during clear is discarded. The debouncer is not reset by clear.
- Opcodes above 2 are captured as-is: op_valid=0 and start still asserts. The ALU default case then drives zeros.
- a, b, op and start change only on clock edges; there is no combinational path from sw to any ALU input.

Decomposition:
- Package alu_lab_pkg holds:
  - state_t enum {S_A, S_B, S_OP, S_RUN}, encoded 2 bits.
  - Opcode constants OP_ADD=4'b0000, OP_SUB=4'b0001, OP_MUL=4'b0010.
  - OP_MAX=4'd2, used by op_valid.
- Sub-module button_debouncer (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_raw, level, rise_pulse) contains the synchroniser, counter and edge detector. It is instantiated once, for btn_load.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then hold btn_load high for 10 cycles with sw=4'd3 -> a=3 exactly 6 edges after the first sample, state_led=4'b0010, start=0, and only one capture for the whole hold.
2. Full sequence with sw=5, 7, 0 and clean presses -> a=5, b=7, op=OP_ADD, start=1, state_led=4'b1000, op_valid=1.
3. 3-cycle btn_load glitch in S_B -> no event, b unchanged, state_led stays 4'b0010.
4. In S_RUN press load -> start=0, state S_A, and a=5, b=7, op=0 retained; then sw=9 and press -> a=9.
5. btn_clear asserted in the same cycle a load_evt would fire in S_OP -> a=b=op=0, S_A, no op capture. Separately, rst asserted mid-debounce -> all outputs zero and a debounce restart is needed.
6. Op capture with sw=4'b1111 -> op=15, op_valid=0, start=1.

Source files
------------

// File: rtl/alu_lab_pkg.sv
// Shared types and constants for the ALU lab front end.
// Covers the operand-sequencing states and the opcodes the ALU decodes.
package alu_lab_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RUN = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_MAX = 4'd2;

    // One-hot LED pattern for a sequencing state
    function automatic logic [3:0] state_to_led(input state_t st);
        logic [3:0] led;
        case (st)
            S_A:     led = 4'b0001;
            S_B:     led = 4'b0010;
            S_OP:    led = 4'b0100;
            S_RUN:   led = 4'b1000;
            default: led = 4'b0001;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stable-level debouncer and rising-edge pulse for one push-button.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive differing synced samples.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;

    // Next-state for synchroniser, stability counter and debounced level
    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        level_d     = level_q;
        level_dly_d = level_q;
        cnt_d       = cnt_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
                cnt_d   = CNT_ZERO;
            end else begin
                cnt_d   = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = CNT_ZERO;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= CNT_ZERO;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = level_q & ~level_dly_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Sequences A, B and opcode capture from a shared switch bank on debounced load presses,
// then holds start so the ALU result stays visible; a synced clear returns to S_A.
module alu_operand_loader
    import alu_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_load,
    input  logic       btn_clear,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [3:0] op,
    output logic       start,
    output logic [3:0] state_led,
    output logic       op_valid
);

    logic       load_level;
    logic       load_evt;

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] op_q, op_d;
    logic       start_q, start_d;
    logic [3:0] led_q, led_d;
    logic       clr_sync1_q, clr_sync1_d;
    logic       clr_sync2_q, clr_sync2_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_load_db (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_load),
        .level      (load_level),
        .rise_pulse (load_evt)
    );

    // Sequencer next-state; clear has priority and swallows a coincident load event
    always_comb begin
        clr_sync1_d = btn_clear;
        clr_sync2_d = clr_sync1_q;
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        if (clr_sync2_q) begin
            state_d = S_A;
            a_d     = 4'd0;
            b_d     = 4'd0;
            op_d    = 4'd0;
        end else if (load_evt) begin
            case (state_q)
                S_A: begin
                    a_d     = sw;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw;
                    state_d = S_OP;
                end
                S_OP: begin
                    op_d    = sw;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    state_d = S_A;
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        start_d = (state_d == S_RUN);
        led_d   = state_to_led(state_d);
    end

    // Sequencer and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_A;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            op_q        <= 4'd0;
            start_q     <= 1'b0;
            led_q       <= 4'b0001;
            clr_sync1_q <= 1'b0;
            clr_sync2_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            start_q     <= start_d;
            led_q       <= led_d;
            clr_sync1_q <= clr_sync1_d;
            clr_sync2_q <= clr_sync2_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign op        = op_q;
    assign start     = start_q;
    assign state_led = led_q;
    assign op_valid  = (op_q <= OP_MAX);

    logic unused_s;
    assign unused_s = load_level;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader with DEBOUNCE_CYCLES=4.
module tb_alu_operand_loader;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       btn_load;
    logic       btn_clear;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic       start;
    logic [3:0] state_led;
    logic       op_valid;

    alu_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn_load  (btn_load),
        .btn_clear (btn_clear),
        .a         (a),
        .b         (b),
        .op        (op),
        .start     (start),
        .state_led (state_led),
        .op_valid  (op_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic       start;
        logic [3:0] led;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int         m_st = 0;
    logic [3:0] m_a  = 4'd0;
    logic [3:0] m_b  = 4'd0;
    logic [3:0] m_op = 4'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.a     = m_a;
        e.b     = m_b;
        e.op    = m_op;
        e.start = (m_st == 3);
        e.led   = 4'b0001 << m_st;
        return e;
    endfunction

    task automatic model_press(input logic [3:0] v);
        case (m_st)
            0: begin m_a  = v; m_st = 1; end
            1: begin m_b  = v; m_st = 2; end
            2: begin m_op = v; m_st = 3; end
            default: m_st = 0;
        endcase
    endtask

    task automatic model_zero();
        m_st = 0;
        m_a  = 4'd0;
        m_b  = 4'd0;
        m_op = 4'd0;
    endtask

    task automatic compare_snapshot(input string tag);
        exp_t e;
        check_eq({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({tag, "_a"}, a, e.a);
            check_eq({tag, "_b"}, b, e.b);
            check_eq({tag, "_op"}, op, e.op);
            check_eq({tag, "_start"}, start, e.start);
            check_eq({tag, "_led"}, state_led, e.led);
            check_eq({tag, "_op_valid"}, op_valid, (e.op <= 4'd2));
        end
    endtask

    // Clean press: 8 cycles high, 8 cycles low, then compare
    task automatic press(input logic [3:0] v, input string tag);
        sw       = v;
        btn_load = 1'b1;
        model_press(v);
        sb.push_back(snap());
        repeat (8) @(negedge clk);
        btn_load = 1'b0;
        repeat (8) @(negedge clk);
        compare_snapshot(tag);
    endtask

    initial begin
        rst       = 1'b1;
        sw        = 4'd0;
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        repeat (2) @(negedge clk);
        model_zero();
        sb.push_back(snap());
        compare_snapshot("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Long hold: exact capture latency and a single capture
        sw       = 4'd3;
        btn_load = 1'b1;
        model_press(4'd3);
        sb.push_back(snap());
        repeat (6) @(negedge clk);
        check_eq("t1_a_before_k6", a, 4'd0);
        @(negedge clk);
        check_eq("t1_a_at_k6", a, 4'd3);
        check_eq("t1_led_at_k6", state_led, 4'b0010);
        repeat (3) @(negedge clk);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
        compare_snapshot("t1_hold");

        // Short glitch in S_B
        sw       = 4'hA;
        btn_load = 1'b1;
        repeat (3) @(negedge clk);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
        sb.push_back(snap());
        compare_snapshot("t3_glitch");

        press(4'd1, "t2_pre_b");
        press(4'd0, "t2_pre_op");
        press(4'd0, "t2_pre_back");

        // Full sequence
        press(4'd5, "t2_a");
        press(4'd7, "t2_b");
        press(4'd0, "t2_op");
        check_eq("t2_op_valid", op_valid, 1'b1);

        press(4'd4, "t4_run_to_a");
        press(4'd9, "t4_new_a");
        press(4'd7, "t5_b");

        // Clear coincides with the S_OP load event
        sw       = 4'd2;
        btn_load = 1'b1;
        repeat (4) @(negedge clk);
        btn_clear = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t5_clr_op", op, 4'd0);
        check_eq("t5_clr_start", start, 1'b0);
        check_eq("t5_clr_led", state_led, 4'b0001);
        check_eq("t5_clr_a", a, 4'd0);
        repeat (2) @(negedge clk);
        btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
        model_zero();
        sb.push_back(snap());
        compare_snapshot("t5_after_clear");

        // Reset in the middle of a debounce
        press(4'd6, "t5_pre_rst");
        sw       = 4'd6;
        btn_load = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_zero();
        sb.push_back(snap());
        compare_snapshot("t5_rst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("t5_restart_led", state_led, 4'b0001);
        check_eq("t5_restart_a", a, 4'd0);
        repeat (5) @(negedge clk);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
        model_press(4'd6);
        sb.push_back(snap());
        compare_snapshot("t5_restart_cap");

        // Out-of-range opcode
        press(4'd4, "t6_b");
        press(4'hF, "t6_op");
        check_eq("t6_op_valid", op_valid, 1'b0);
        check_eq("t6_start", start, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
